imm_decode_stage: RTL
=====================

// Module: imm_decode_stage
// PURPOSE
//   Pipeline stage directly upstream of the 16->32 immediate extender. Accepts
//   32-bit MIPS instruction words over a valid/ready handshake and decodes the
//   6-bit opcode. It emits the 16-bit immediate field (feeds extender input a)
//   and the sext select (feeds extender input sext). A 2-entry skid buffer
//   gives full throughput with a registered in_ready.
// PARAMETERS
//   ERR_W    8   width of saturating unsupported-opcode counter
// PORTS
//   clk        in   1       rising-edge clock
//   rst_n      in   1       asynchronous active-low reset
//   in_valid   in   1       instruction word valid
//   in_ready   out  1       stage can accept (registered)
//   in_instr   in   32      instruction word
//   out_valid  out  1       decoded entry valid
//   out_ready  in   1       downstream accepts
//   out_imm    out  16      instr[15:0], to extender a
//   out_sext   out  1       1=sign-extend, 0=zero-extend, to extender sext
//   out_is_imm out  1       opcode is a supported I-type
//   out_op     out  6       instr[31:26]
//   err_cnt    out  ERR_W   count of accepted unsupported opcodes, saturating
// BEHAVIOUR
//   - Reset (rst_n=0, async): buffer empty, out_valid=0, in_ready=1, out_imm=0,
//     out_sext=0, out_is_imm=0, out_op=0, err_cnt=0. Takes effect mid-transfer;
//     held entries are discarded.
//   - Transfer in when in_valid&in_ready; out when out_valid&out_ready.
//   - Decode at input, stored with the entry:
//     sext=1, is_imm=1: op 0x04 beq, 0x05 bne, 0x08 addi, 0x09 addiu,
//       0x0A slti, 0x0B sltiu, 0x23 lw, 0x2B sw.
//     sext=0, is_imm=1: 0x0C andi, 0x0D ori, 0x0E xori, 0x0F lui.
//     All other ops: sext=0, is_imm=0; imm still passed through.
//   - Latency: an accepted word appears on out_* on the next cycle (1 cycle).
//   - FSM over occupancy: EMPTY(0) / ONE(1) / FULL(2).
//     EMPTY: accept -> ONE.
//     ONE: accept&!pop -> FULL; pop&!accept -> EMPTY; both -> ONE.
//     FULL: pop -> ONE. No accept, because in_ready=0.
//   - in_ready = (state!=FULL). It is registered and is computed from the
//     next state.
//   - out_valid = (state!=EMPTY). out_* show the oldest entry (FIFO order).
//   - out_* remain stable while out_valid&!out_ready.
//   - When out_valid=0, out_* hold their last values. Consumers ignore them.
//   - err_cnt increments by 1 on each accepted word with is_imm=0.
//     It saturates at 2^ERR_W-1 and does not wrap.
//   - Simultaneous push and pop in ONE: the new word becomes head next cycle.
//     No bubble.
// TESTING
//   1. Reset, then push 0x2008FFFF (addi) with out_ready=1 -> next cycle
//      out_valid=1, out_imm=0xFFFF, out_sext=1, out_is_imm=1, out_op=0x08.
//   2. Push 0x3508FFFF (ori) -> out_imm=0xFFFF, out_sext=0, out_is_imm=1.
//      Push 0x8C088000 (lw) -> out_imm=0x8000, out_sext=1.
//   3. out_ready=0, then push 0x20080001 and 0x20080002 -> in_ready=0 after
//      the 2nd push. The third word is held off. Raise out_ready ->
//      0x0001 then 0x0002 in order, no drop or duplicate.
//   4. Stream 20 words, in_valid=1 and out_ready=1 every cycle -> one output
//      per cycle, in order, in_ready stays 1.
//   5. Push 0x00000020 (R-type, op 0) -> out_is_imm=0, out_sext=0,
//      err_cnt=1. With ERR_W=2, push 5 such words -> err_cnt saturates at 3.
//   6. Assert rst_n=0 asynchronously while FULL -> out_valid=0, in_ready=1,
//      err_cnt=0 immediately, with no clock edge needed.

Source files
------------

// File: rtl/imm_decode_stage.sv
// Decode stage ahead of the 16->32 immediate extender: classifies MIPS opcodes,
// forwards imm/sext through a 2-entry skid buffer with a registered in_ready.
module imm_decode_stage #(
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_imm,
  output logic             out_sext,
  output logic             out_is_imm,
  output logic [5:0]       out_op,
  output logic [ERR_W-1:0] err_cnt
);

  // state | meaning
  // EMPTY | no entry held, out_* show the last head
  // ONE   | head valid on out_*, skid slot free
  // FULL  | head and skid both valid, in_ready low
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam int ENT_W = 24;  // {op[5:0], sext, is_imm, imm[15:0]}

  state_t             r_state;
  state_t             w_next;
  logic               r_in_ready;
  logic [ENT_W-1:0]   r_head;
  logic [ENT_W-1:0]   r_skid;
  logic [ERR_W-1:0]   r_err_cnt;
  logic               w_sext;
  logic               w_is_imm;
  logic               w_accept;
  logic               w_pop;
  logic [ENT_W-1:0]   w_entry;

  always_comb begin
    w_sext   = 1'b0;
    w_is_imm = 1'b0;
    case (in_instr[31:26])
      6'h04, 6'h05, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h23, 6'h2B: begin
        w_sext   = 1'b1;
        w_is_imm = 1'b1;
      end
      6'h0C, 6'h0D, 6'h0E, 6'h0F: w_is_imm = 1'b1;
      default: ;
    endcase
  end

  assign w_entry  = {in_instr[31:26], w_sext, w_is_imm, in_instr[15:0]};
  assign w_accept = in_valid & r_in_ready;
  assign w_pop    = (r_state != EMPTY) & out_ready;

  always_comb begin
    w_next = r_state;
    case (r_state)
      EMPTY: if (w_accept) w_next = ONE;
      ONE: begin
        if (w_accept && !w_pop)      w_next = FULL;
        else if (w_pop && !w_accept) w_next = EMPTY;
      end
      FULL:  if (w_pop) w_next = ONE;
      default: w_next = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= EMPTY;
      r_in_ready <= 1'b1;
      r_head     <= '0;
      r_skid     <= '0;
      r_err_cnt  <= '0;
    end else begin
      r_state    <= w_next;
      r_in_ready <= (w_next != FULL);
      case (r_state)
        EMPTY: if (w_accept) r_head <= w_entry;
        ONE: begin
          // Push with pop lets the new word become head with no bubble.
          if (w_accept && w_pop) r_head <= w_entry;
          else if (w_accept)     r_skid <= w_entry;
        end
        FULL:  if (w_pop) r_head <= r_skid;
        default: ;
      endcase
      if (w_accept && !w_is_imm && (r_err_cnt != {ERR_W{1'b1}}))
        r_err_cnt <= r_err_cnt + 1'b1;
    end
  end

  assign in_ready   = r_in_ready;
  assign out_valid  = (r_state != EMPTY);
  assign out_op     = r_head[23:18];
  assign out_sext   = r_head[17];
  assign out_is_imm = r_head[16];
  assign out_imm    = r_head[15:0];
  assign err_cnt    = r_err_cnt;

endmodule
